gpr_wb_arbiter: RTL
===================

// Module: gpr_wb_arbiter
// PURPOSE
//  Shares the single GPR write port between the ALU writeback stage and the
//  load/MMIO return path. ALU has fixed priority; load returns are buffered
//  in a small FIFO and drained in idle slots, with a starvation escape that
//  stalls the ALU. A pending-load scoreboard lets decode stall on RAW hazards.
// PARAMETERS
//  DEPTH         2   load return FIFO entries (power of two, >=2)
//  STARVE_LIMIT  4   consecutive lost slots before forcing a load drain (>=1)
// PORTS
//  clk           in   1   clock
//  rst           in   1   asynchronous reset, active-high
//  alu_valid     in   1   ALU result present this cycle (cannot be back-pressured)
//  alu_rd        in   5   ALU destination register
//  alu_data      in   32  ALU result
//  ld_valid      in   1   load return data valid
//  ld_ready      out  1   FIFO can accept: !full (does not depend on pop)
//  ld_rd         in   5   load destination register
//  ld_data       in   32  load return data
//  ld_issue      in   1   load issued by the pipeline; mark ld_issue_rd pending
//  ld_issue_rd   in   5   destination of the issued load
//  pend          out  32  registered scoreboard, bit i = load to xi outstanding
//  wb_stall      out  1   pipeline must present alu_valid=0 in the next cycle
//  gpr_we        out  1   GPR write enable (registered)
//  gpr_rd        out  5   GPR write index (registered)
//  gpr_rrd       out  32  GPR write data (registered)
//  err           out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pend=0, starve counter=0, err=0; ld_ready=1 after reset.
//  Latency: a winning request appears on gpr_we/rd/rrd exactly 1 cycle later.
//  Arbitration each cycle (state FORCE = wb_stall was 1 last cycle):
//   - alu_valid=1: ALU wins; FIFO not popped; if FIFO non-empty, cnt++.
//   - alu_valid=0 and FIFO non-empty: pop head, write it; cnt=0.
//   - FORCE and alu_valid=1: ALU still wins (no data lost), err<=1.
//   - FIFO empty: cnt=0.
//  wb_stall=1 for one cycle when cnt reaches STARVE_LIMIT with FIFO non-empty;
//   cnt then holds until a pop occurs; wb_stall never asserted two cycles running.
//  Load path bypass: FIFO is always used (no combinational ld->gpr path), so
//   a load into an empty FIFO with no ALU traffic writes 2 cycles after ld_valid.
//  Push when ld_valid && ld_ready; push+pop in same cycle allowed when not full.
//   ld_valid while !ld_ready: beat dropped, err<=1.
//  rd==0: winner with rd 0 is consumed (FIFO popped) but gpr_we stays 0;
//   gpr_we=1 is never driven with gpr_rd==0.
//  Scoreboard: ld_issue sets pend[ld_issue_rd] (ignored for rd 0); a popped
//   load clears pend[its rd] in the same edge. Set and clear of the same rd
//   in one cycle: set wins. ALU win with pend[alu_rd]=1 (WAW): err<=1.
//  err clears only on rst. Reset asserted mid-operation discards FIFO contents
//   and pending bits immediately (asynchronous), gpr_we drops to 0.
//  FIFO pointers wrap modulo DEPTH; full/empty from an extra pointer bit.
// TESTING
//  1 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle gpr_we=1, rd=5, rrd=0xDEADBEEF.
//  2 Idle drain: ld_valid rd=7 data=0x1234, no ALU -> gpr_we=1 rd=7 two cycles later;
//    ld_issue rd=7 earlier -> pend[7] 1 then 0 on the write edge.
//  3 Starvation: alu_valid every cycle, one load queued -> wb_stall=1 after 4 lost
//    slots; bench drops alu_valid next cycle -> load written, pend bit cleared.
//  4 Full FIFO: 2 loads queued under ALU traffic -> ld_ready=0; 3rd ld_valid ->
//    err=1, FIFO contents unchanged, both queued loads written in order.
//  5 rd==0: ALU rd=0 and load rd=0 -> no gpr_we pulse, load popped, pend[0]=0.
//  6 Async reset with 2 loads queued mid-stream -> pend=0, gpr_we=0, ld_ready=1
//    without a clock edge; no queued load written after release.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-port arbiter between ALU writeback and buffered load returns
// ALU has fixed priority; loads drain from a small FIFO with a starvation escape and RAW scoreboard.
module gpr_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic [31:0] pend,
    output logic        wb_stall,
    output logic        gpr_we,
    output logic [4:0]  gpr_rd,
    output logic [31:0] gpr_rrd,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    state_t state, state_next;

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full;
    logic [CW-1:0] cnt, cnt_next;
    logic          push, pop, win, viol;
    logic [4:0]    win_rd, head_rd;
    logic [31:0]   win_data;
    logic [31:0]   pend_next;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign ld_ready = !full;
    assign head_rd  = fifo_rd[rptr[AW-1:0]];

    always_comb begin
        state_next = ST_NORMAL;
        wb_stall   = 1'b0;
        pop        = 1'b0;
        win        = 1'b0;
        win_rd     = alu_rd;
        win_data   = alu_data;
        cnt_next   = cnt;
        viol       = 1'b0;
        push       = ld_valid && !full;
        pend_next  = pend;

        // Stall is a single-cycle request; the cycle after it is the FORCE slot
        wb_stall = (cnt == CW'(STARVE_LIMIT)) && !empty && (state == ST_NORMAL);
        if (wb_stall) begin
            state_next = ST_FORCE;
        end

        if (alu_valid) begin
            win = 1'b1;
            if ((state == ST_FORCE) || pend[alu_rd]) begin
                viol = 1'b1;
            end
            if (empty) begin
                cnt_next = '0;
            end else if (cnt != CW'(STARVE_LIMIT)) begin
                cnt_next = cnt + CW'(1);
            end
        end else if (!empty) begin
            pop      = 1'b1;
            win      = 1'b1;
            win_rd   = head_rd;
            win_data = fifo_data[rptr[AW-1:0]];
            cnt_next = '0;
        end else begin
            cnt_next = '0;
        end

        if (ld_valid && full) begin
            viol = 1'b1;
        end

        // Clear before set so an issue to the same register in this cycle wins
        if (pop) begin
            pend_next[head_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != 5'd0)) begin
            pend_next[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr[AW-1:0]]   <= ld_rd;
            fifo_data[wptr[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_NORMAL;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            pend    <= '0;
            err     <= 1'b0;
            gpr_we  <= 1'b0;
            gpr_rd  <= '0;
            gpr_rrd <= '0;
        end else begin
            state  <= state_next;
            wptr   <= wptr + (AW + 1)'(push);
            rptr   <= rptr + (AW + 1)'(pop);
            cnt    <= cnt_next;
            pend   <= pend_next;
            err    <= err | viol;
            gpr_we <= win && (win_rd != 5'd0);
            if (win && (win_rd != 5'd0)) begin
                gpr_rd  <= win_rd;
                gpr_rrd <= win_data;
            end
        end
    end
endmodule
